tlc_multi: RTL and testbench

Parametrised N-phase traffic light controller. It extends the fixed two-way green/yellow/all-red sequencer with:
- configurable phase count and durations;
- a tick-enable timebase;
- demand-driven phase skipping and green gap-out;
- a night flashing mode.

It sits between the intersection timebase divider and the lamp drivers. All outputs are registered.

---
 rtl/tlc_multi.sv | 142 ++++++++++++++
 tb/tb_tlc_multi.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/tlc_multi.sv
// N-phase traffic light controller: demand-driven phase selection, green gap-out,
// tick-enabled timers and a night flashing mode. All outputs are registered.
module tlc_multi #(
  parameter int N_PHASE     = 2,
  parameter int CNT_W       = 5,
  parameter int T_GREEN     = 16,
  parameter int T_GREEN_MIN = 6,
  parameter int T_YELLOW    = 4,
  parameter int T_ALLRED    = 4,
  parameter int T_FLASH     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic [N_PHASE-1:0]     req,
  input  logic                   night,
  output logic [3*N_PHASE-1:0]   lights,
  output logic [2:0]             phase,
  output logic                   flash
);

  typedef enum logic [1:0] {GREEN, YELLOW, ALLRED, FLASH} state_t;

  localparam logic [N_PHASE-1:0] ONE      = N_PHASE'(1);
  localparam logic [2:0]         LAST     = 3'(N_PHASE - 1);
  localparam logic [CNT_W-1:0]   G_END    = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0]   GMIN_END = CNT_W'(T_GREEN_MIN - 1);
  localparam logic [CNT_W-1:0]   Y_END    = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0]   A_END    = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0]   F_END    = CNT_W'(T_FLASH - 1);

  state_t               state, state_n;
  logic [2:0]           cur, cur_n, nxt;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic                 lamp_on, lamp_on_n;
  logic [N_PHASE-1:0]   cur_oh;
  logic                 cur_req, other_req, found;
  logic [3*N_PHASE-1:0] lights_n;

  // Next served phase: first requesting index after cur (cur itself last),
  // falling back to cur+1 when nothing is requested.
  always_comb begin
    cur_oh    = ONE << cur;
    cur_req   = |(req & cur_oh);
    other_req = |(req & ~cur_oh);
    nxt       = 3'((32'(cur) + 32'd1) % 32'(N_PHASE));
    found     = 1'b0;
    for (int unsigned k = 1; k <= 32'(N_PHASE); k++) begin
      if (!found && |(req & (ONE << ((32'(cur) + k) % 32'(N_PHASE))))) begin
        nxt   = 3'((32'(cur) + k) % 32'(N_PHASE));
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n   = state;
    cur_n     = cur;
    cnt_n     = cnt;
    lamp_on_n = lamp_on;
    if (tick) begin
      cnt_n = cnt + 1'b1;
      case (state)
        GREEN: begin
          if (cnt == G_END || (cnt >= GMIN_END && !cur_req && other_req)) begin
            state_n = YELLOW;
            cnt_n   = '0;
          end
        end
        YELLOW: begin
          if (cnt == Y_END) begin
            state_n = ALLRED;
            cnt_n   = '0;
          end
        end
        ALLRED: begin
          if (cnt == A_END) begin
            cnt_n = '0;
            if (night) begin
              state_n   = FLASH;
              cur_n     = '0;
              lamp_on_n = 1'b1;
            end else begin
              state_n = GREEN;
              cur_n   = nxt;
            end
          end
        end
        FLASH: begin
          if (cnt == F_END) begin
            cnt_n = '0;
            if (lamp_on) begin
              lamp_on_n = 1'b0;
            end else if (night) begin
              lamp_on_n = 1'b1;
            end else begin
              state_n = ALLRED;
              cur_n   = LAST;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Lamps are decoded from the next state so they change on the same edge.
  always_comb begin
    lights_n = '0;
    for (int unsigned i = 0; i < 32'(N_PHASE); i++) begin
      if (state_n == FLASH)
        lights_n[3*i +: 3] = lamp_on_n ? ((i == 0) ? 3'b010 : 3'b100) : 3'b000;
      else if (state_n == GREEN && cur_n == 3'(i))
        lights_n[3*i +: 3] = 3'b001;
      else if (state_n == YELLOW && cur_n == 3'(i))
        lights_n[3*i +: 3] = 3'b010;
      else
        lights_n[3*i +: 3] = 3'b100;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ALLRED;
      cur     <= LAST;
      cnt     <= '0;
      lamp_on <= 1'b0;
      lights  <= {N_PHASE{3'b100}};
      phase   <= LAST;
      flash   <= 1'b0;
    end else begin
      state   <= state_n;
      cur     <= cur_n;
      cnt     <= cnt_n;
      lamp_on <= lamp_on_n;
      lights  <= lights_n;
      phase   <= cur_n;
      flash   <= (state_n == FLASH);
    end
  end

endmodule

// File: tb/tb_tlc_multi.sv
// Directed scoreboard bench for tlc_multi: 2-phase and 4-phase instances,
// covering sequencing, demand skipping, gap-out, night flash, tick scaling and async reset.
module tb_tlc_multi;

  logic        clk = 1'b0;
  logic        rst, rst4, tick, night;
  logic [1:0]  req;
  logic [3:0]  req4;
  logic [5:0]  lights2;
  logic [11:0] lights4;
  logic [2:0]  phase2, phase4;
  logic        flash2, flash4;

  int n_checks = 0;
  int n_fail   = 0;
  int tdiv     = 1;
  int tdiv_ctr = 0;

  typedef struct {
    logic        sel;
    logic [11:0] l;
    logic [2:0]  p;
    logic        f;
    string       tag;
  } exp_t;
  exp_t q[$];

  localparam logic [11:0] L_AR  = 12'b000000_100100;
  localparam logic [11:0] L_G0  = 12'b000000_100001;
  localparam logic [11:0] L_Y0  = 12'b000000_100010;
  localparam logic [11:0] L_G1  = 12'b000000_001100;
  localparam logic [11:0] L_Y1  = 12'b000000_010100;
  localparam logic [11:0] L_FON = 12'b000000_100010;
  localparam logic [11:0] L_OFF = 12'b000000_000000;
  localparam logic [11:0] L4_AR = 12'b100_100_100_100;
  localparam logic [11:0] L4_G2 = 12'b100_001_100_100;
  localparam logic [11:0] L4_Y2 = 12'b100_010_100_100;

  tlc_multi #(.N_PHASE(2)) u_dut2 (
    .clk(clk), .rst(rst), .tick(tick), .req(req), .night(night),
    .lights(lights2), .phase(phase2), .flash(flash2)
  );

  tlc_multi #(.N_PHASE(4)) u_dut4 (
    .clk(clk), .rst(rst4), .tick(tick), .req(req4), .night(night),
    .lights(lights4), .phase(phase4), .flash(flash4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic sel, input logic [11:0] l,
                     input logic [2:0] p, input logic f);
    logic [15:0] obs, ex;
    obs = sel ? {lights4, phase4, flash4} : {6'b0, lights2, phase2, flash2};
    ex  = {l, p, f};
    n_checks++;
    assert (obs === ex) else begin
      n_fail++;
      $error("FAIL %s: observed lights/phase/flash=%h expected %h", tag, obs, ex);
    end
  endtask

  task automatic push(input logic sel, input logic [11:0] l, input logic [2:0] p,
                      input logic f, input int n, input string tag);
    for (int i = 0; i < n; i++) q.push_back('{sel, l, p, f, tag});
  endtask

  // One expected entry per clock; tick is generated 1-in-tdiv ahead of each edge.
  task automatic drain();
    exp_t e;
    while (q.size() > 0) begin
      tick = (tdiv_ctr == 0);
      tdiv_ctr = (tdiv_ctr + 1) % tdiv;
      @(posedge clk);
      #1;
      e = q.pop_front();
      chk(e.tag, e.sel, e.l, e.p, e.f);
    end
  endtask

  initial begin
    rst = 1'b1; rst4 = 1'b1; tick = 1'b1; night = 1'b0;
    req = 2'b11; req4 = 4'b0100;
    repeat (2) @(posedge clk);
    #1;
    chk("reset2", 1'b0, L_AR, 3'd1, 1'b0);
    chk("reset4", 1'b1, L4_AR, 3'd3, 1'b0);

    // Only req[2] on four phases: 3 -> 2, then 2 again.
    rst4 = 1'b0;
    push(1'b1, L4_AR, 3'd3, 1'b0, 3,  "n4_ar_init");
    push(1'b1, L4_G2, 3'd2, 1'b0, 16, "n4_g2");
    push(1'b1, L4_Y2, 3'd2, 1'b0, 4,  "n4_y2");
    push(1'b1, L4_AR, 3'd2, 1'b0, 4,  "n4_ar2");
    push(1'b1, L4_G2, 3'd2, 1'b0, 2,  "n4_g2_again");
    drain();
    rst4 = 1'b1;

    // Basic two-phase sequence.
    rst = 1'b0;
    chk("release2", 1'b0, L_AR, 3'd1, 1'b0);
    push(1'b0, L_AR, 3'd1, 1'b0, 3,  "t1_ar_init");
    push(1'b0, L_G0, 3'd0, 1'b0, 16, "t1_g0");
    push(1'b0, L_Y0, 3'd0, 1'b0, 4,  "t1_y0");
    push(1'b0, L_AR, 3'd0, 1'b0, 4,  "t1_ar0");
    push(1'b0, L_G1, 3'd1, 1'b0, 16, "t1_g1");
    drain();

    // Gap-out: phase 0 green with req=10 from entry.
    push(1'b0, L_Y1, 3'd1, 1'b0, 4, "t3_y1");
    push(1'b0, L_AR, 3'd1, 1'b0, 4, "t3_ar1");
    push(1'b0, L_G0, 3'd0, 1'b0, 1, "t3_g0_entry");
    drain();
    req = 2'b10;
    push(1'b0, L_G0, 3'd0, 1'b0, 5,  "t3_g0_gap");
    push(1'b0, L_Y0, 3'd0, 1'b0, 4,  "t3_y0");
    push(1'b0, L_AR, 3'd0, 1'b0, 4,  "t3_ar0");
    push(1'b0, L_G1, 3'd1, 1'b0, 16, "t3_g1_full");
    drain();
    req = 2'b11;

    // Night mode entry and exit.
    push(1'b0, L_Y1, 3'd1, 1'b0, 4, "t4_y1");
    push(1'b0, L_AR, 3'd1, 1'b0, 4, "t4_ar1");
    push(1'b0, L_G0, 3'd0, 1'b0, 1, "t4_g0_entry");
    drain();
    night = 1'b1;
    push(1'b0, L_G0,  3'd0, 1'b0, 15, "t4_g0");
    push(1'b0, L_Y0,  3'd0, 1'b0, 4,  "t4_y0");
    push(1'b0, L_AR,  3'd0, 1'b0, 4,  "t4_ar0");
    push(1'b0, L_FON, 3'd0, 1'b1, 2,  "t4_flash_on1");
    push(1'b0, L_OFF, 3'd0, 1'b1, 2,  "t4_flash_off1");
    push(1'b0, L_FON, 3'd0, 1'b1, 2,  "t4_flash_on2");
    push(1'b0, L_OFF, 3'd0, 1'b1, 1,  "t4_flash_off2a");
    drain();
    night = 1'b0;
    push(1'b0, L_OFF, 3'd0, 1'b1, 1,  "t4_flash_off2b");
    push(1'b0, L_AR,  3'd1, 1'b0, 4,  "t4_ar_exit");
    push(1'b0, L_G0,  3'd0, 1'b0, 16, "t4_g0_after");
    push(1'b0, L_Y0,  3'd0, 1'b0, 2,  "t6_y0_pre");
    drain();

    // Async reset mid-yellow, between edges.
    #2 rst = 1'b1;
    #1 chk("t6_async_rst", 1'b0, L_AR, 3'd1, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t6_release", 1'b0, L_AR, 3'd1, 1'b0);
    push(1'b0, L_AR, 3'd1, 1'b0, 3,  "t6_ar_init");
    push(1'b0, L_G0, 3'd0, 1'b0, 16, "t6_g0");
    push(1'b0, L_Y0, 3'd0, 1'b0, 1,  "t6_y0");
    drain();

    // Tick pulsed 1-in-3.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tdiv = 3;
    tdiv_ctr = 0;
    chk("t5_release", 1'b0, L_AR, 3'd1, 1'b0);
    push(1'b0, L_AR, 3'd1, 1'b0, 9,  "t5_ar_init");
    push(1'b0, L_G0, 3'd0, 1'b0, 48, "t5_g0");
    push(1'b0, L_Y0, 3'd0, 1'b0, 12, "t5_y0");
    push(1'b0, L_AR, 3'd0, 1'b0, 12, "t5_ar0");
    push(1'b0, L_G1, 3'd1, 1'b0, 3,  "t5_g1");
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
